result_bus_arbiter: RTL and testbench

// Collects finished results from UNITS execution-unit wrappers over their

---
 rtl/result_bus_arbiter_if.sv | 46 ++++
 rtl/result_bus_arbiter.sv | 87 ++++++++
 tb/tb_result_bus_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/result_bus_arbiter_if.sv
// Flag type shared by units and bus, plus the interface that bundles the
// per-unit result ports and the registered broadcast bus.
package result_bus_arbiter_pkg;
  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic so;
    logic ov;
    logic ca;
  } cond_exception_t;
endpackage

interface result_bus_arbiter_if #(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
);
  import result_bus_arbiter_pkg::*;

  logic [0:UNITS-1]       unit_valid;
  logic [0:UNITS-1]       unit_ready;
  logic [RS_ID_WIDTH-1:0] unit_rs_id           [UNITS];
  logic [0:4]             unit_result_reg_addr [UNITS];
  logic [0:31]            unit_result          [UNITS];
  cond_exception_t        unit_cr0_xer         [UNITS];

  logic                       bus_valid;
  logic [RS_ID_WIDTH-1:0]     bus_rs_id;
  logic [0:4]                 bus_result_reg_addr;
  logic [0:31]                bus_result;
  cond_exception_t            bus_cr0_xer;
  logic [$clog2(UNITS)-1:0]   bus_unit;

  // master = arbiter side, slave = units and bus consumers
  modport master (
    input  unit_valid, unit_rs_id, unit_result_reg_addr, unit_result, unit_cr0_xer,
    output unit_ready,
    output bus_valid, bus_rs_id, bus_result_reg_addr, bus_result, bus_cr0_xer, bus_unit
  );

  modport slave (
    output unit_valid, unit_rs_id, unit_result_reg_addr, unit_result, unit_cr0_xer,
    input  unit_ready,
    input  bus_valid, bus_rs_id, bus_result_reg_addr, bus_result, bus_cr0_xer, bus_unit
  );
endinterface

// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter that serialises execution-unit results onto one
// registered broadcast bus with single-cycle latency and no backpressure.
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  result_bus_arbiter_if.master rb
);

  localparam int UW = $clog2(UNITS);

  logic [UW-1:0] ptr_q, ptr_d;
  logic [UW-1:0] grant;
  logic [UW:0]   scan_sum;
  logic          any_vld;
  logic          xfer;

  logic                   bus_valid_q;
  logic [RS_ID_WIDTH-1:0] bus_rs_id_q;
  logic [0:4]             bus_reg_addr_q;
  logic [0:31]            bus_result_q;
  cond_exception_t        bus_cr0_xer_q;
  logic [UW-1:0]          bus_unit_q;

  // Scan from the farthest offset back to ptr so the nearest valid unit wins.
  always_comb begin
    grant    = '0;
    any_vld  = 1'b0;
    scan_sum = '0;
    for (int k = UNITS - 1; k >= 0; k--) begin
      scan_sum = {1'b0, ptr_q} + (UW+1)'(k);
      if (scan_sum >= (UW+1)'(UNITS)) scan_sum = scan_sum - (UW+1)'(UNITS);
      if (rb.unit_valid[scan_sum[UW-1:0]]) begin
        grant   = scan_sum[UW-1:0];
        any_vld = 1'b1;
      end
    end
  end

  assign xfer = any_vld & ~flush & ~rst;

  always_comb begin
    rb.unit_ready = '0;
    if (xfer) rb.unit_ready[grant] = 1'b1;
  end

  // Explicit wrap keeps non-power-of-two UNITS correct.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (grant == UW'(UNITS - 1)) ? '0 : grant + UW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      bus_valid_q    <= 1'b0;
      bus_rs_id_q    <= '0;
      bus_reg_addr_q <= '0;
      bus_result_q   <= '0;
      bus_cr0_xer_q  <= '0;
      bus_unit_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      bus_valid_q <= xfer;
      if (xfer) begin
        bus_rs_id_q    <= rb.unit_rs_id[grant];
        bus_reg_addr_q <= rb.unit_result_reg_addr[grant];
        bus_result_q   <= rb.unit_result[grant];
        bus_cr0_xer_q  <= rb.unit_cr0_xer[grant];
        bus_unit_q     <= grant;
      end
    end
  end

  assign rb.bus_valid           = bus_valid_q;
  assign rb.bus_rs_id           = bus_rs_id_q;
  assign rb.bus_result_reg_addr = bus_reg_addr_q;
  assign rb.bus_result          = bus_result_q;
  assign rb.bus_cr0_xer         = bus_cr0_xer_q;
  assign rb.bus_unit            = bus_unit_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed bench for result_bus_arbiter: reset, single unit, fairness,
// pointer wrap, flush, data path and reset mid-stream.
module tb_result_bus_arbiter;
  import result_bus_arbiter_pkg::*;

  localparam int UNITS       = 4;
  localparam int RS_ID_WIDTH = 5;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_tests = 0;
  int   n_fail  = 0;

  result_bus_arbiter_if #(.UNITS(UNITS), .RS_ID_WIDTH(RS_ID_WIDTH)) rbi ();

  result_bus_arbiter #(.UNITS(UNITS), .RS_ID_WIDTH(RS_ID_WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .rb    (rbi.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready is combinational, so inputs are applied then settled before sampling
  task automatic settle();
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    rbi.unit_valid = 4'b1111;
    for (int i = 0; i < UNITS; i++) begin
      rbi.unit_rs_id[i]           = RS_ID_WIDTH'(10 + i);
      rbi.unit_result_reg_addr[i] = 5'(i);
      rbi.unit_result[i]          = 32'h1000_0000 + 32'(i);
      rbi.unit_cr0_xer[i]         = cond_exception_t'(6'(i));
    end

    // Reset held two cycles with all units requesting
    for (int c = 0; c < 2; c++) begin
      settle();
      check("rst_ready", 64'(rbi.unit_ready), 64'(4'b0000));
      tick();
      check("rst_bus_valid", 64'(rbi.bus_valid), 64'd0);
      check("rst_bus_result", 64'(rbi.bus_result), 64'd0);
      check("rst_bus_rs_id", 64'(rbi.bus_rs_id), 64'd0);
    end
    rst = 1'b0;
    settle();
    check("first_grant_ready", 64'(rbi.unit_ready), 64'(4'b1000));
    tick();
    check("first_grant_valid", 64'(rbi.bus_valid), 64'd1);
    check("first_grant_unit", 64'(rbi.bus_unit), 64'd0);
    check("first_grant_rs", 64'(rbi.bus_rs_id), 64'd10);

    // Idle cycle: valid drops, data holds
    rbi.unit_valid = 4'b0000;
    settle();
    check("idle_ready", 64'(rbi.unit_ready), 64'd0);
    tick();
    check("idle_valid", 64'(rbi.bus_valid), 64'd0);
    check("idle_hold_rs", 64'(rbi.bus_rs_id), 64'd10);

    // Single unit 2, three back-to-back results
    rbi.unit_valid = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      rbi.unit_rs_id[2] = RS_ID_WIDTH'(3 + n);
      settle();
      check("single_ready", 64'(rbi.unit_ready), 64'(4'b0010));
      tick();
      check("single_valid", 64'(rbi.bus_valid), 64'd1);
      check("single_rs", 64'(rbi.bus_rs_id), 64'(3 + n));
      check("single_unit", 64'(rbi.bus_unit), 64'd2);
    end
    rbi.unit_rs_id[2] = RS_ID_WIDTH'(12);

    // Fairness: return ptr to 0, then all units valid continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rbi.unit_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      tick();
      check("fair_valid", 64'(rbi.bus_valid), 64'd1);
      check("fair_unit", 64'(rbi.bus_unit), 64'(n % 4));
      check("fair_rs", 64'(rbi.bus_rs_id), 64'(10 + (n % 4)));
    end

    // Wrap: one grant to unit 2 puts ptr at 3
    rbi.unit_valid = 4'b0010;
    tick();
    rbi.unit_valid = 4'b0101;
    settle();
    check("wrap_ready3", 64'(rbi.unit_ready), 64'(4'b0001));
    tick();
    check("wrap_unit3", 64'(rbi.bus_unit), 64'd3);
    settle();
    check("wrap_ready1", 64'(rbi.unit_ready), 64'(4'b0100));
    tick();
    check("wrap_unit1", 64'(rbi.bus_unit), 64'd1);
    rbi.unit_valid = 4'b0111;
    settle();
    check("wrap_ptr2", 64'(rbi.unit_ready), 64'(4'b0010));
    tick();
    check("wrap_ptr2_unit", 64'(rbi.bus_unit), 64'd2);

    // Flush blocks the grant for one cycle; bus data holds
    rbi.unit_valid     = 4'b0100;
    rbi.unit_result[1] = 32'hDEAD_BEEF;
    flush = 1'b1;
    settle();
    check("flush_ready", 64'(rbi.unit_ready), 64'd0);
    tick();
    check("flush_valid", 64'(rbi.bus_valid), 64'd0);
    check("flush_hold_unit", 64'(rbi.bus_unit), 64'd2);
    flush = 1'b0;
    settle();
    check("postflush_ready", 64'(rbi.unit_ready), 64'(4'b0100));
    tick();
    check("postflush_valid", 64'(rbi.bus_valid), 64'd1);
    check("postflush_result", 64'(rbi.bus_result), 64'hDEAD_BEEF);
    check("postflush_unit", 64'(rbi.bus_unit), 64'd1);

    // Data fields of unit 0 reach the bus unchanged
    rbi.unit_valid              = 4'b1000;
    rbi.unit_result[0]          = 32'h0000_0001;
    rbi.unit_result_reg_addr[0] = 5'd31;
    rbi.unit_rs_id[0]           = RS_ID_WIDTH'(5'h1F);
    rbi.unit_cr0_xer[0]         = cond_exception_t'(6'b101101);
    tick();
    check("data_valid", 64'(rbi.bus_valid), 64'd1);
    check("data_result", 64'(rbi.bus_result), 64'd1);
    check("data_reg_addr", 64'(rbi.bus_result_reg_addr), 64'd31);
    check("data_rs_id", 64'(rbi.bus_rs_id), 64'h1F);
    check("data_cr0_xer", 64'(rbi.bus_cr0_xer), 64'(6'b101101));
    check("data_unit", 64'(rbi.bus_unit), 64'd0);

    // Reset together with flush while a result is pending: reset wins
    rst   = 1'b1;
    flush = 1'b1;
    settle();
    check("rstflush_ready", 64'(rbi.unit_ready), 64'd0);
    tick();
    check("rstflush_valid", 64'(rbi.bus_valid), 64'd0);
    check("rstflush_result", 64'(rbi.bus_result), 64'd0);
    rst   = 1'b0;
    flush = 1'b0;
    rbi.unit_valid = 4'b1001;
    settle();
    check("after_rst_ready", 64'(rbi.unit_ready), 64'(4'b1000));
    tick();
    check("after_rst_unit", 64'(rbi.bus_unit), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
